// File: rtl/jk_mod_counter_pkg.sv
// Shared JK cell types and helpers: the JK operation encoding, the next-state
// function of one cell, and the excitation that moves a cell from q to n.
package jk_pkg;

    // Encoded as {j, k}.
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_t;

    function automatic logic jk_next(input logic q, input jk_op_t op);
        logic n;
        case (op)
            JK_HOLD:   n = q;
            JK_RESET:  n = 1'b0;
            JK_SET:    n = 1'b1;
            JK_TOGGLE: n = ~q;
            default:   n = q;
        endcase
        return n;
    endfunction

    // J = ~q & n, K = q & ~n; never yields toggle.
    function automatic jk_op_t jk_excite(input logic q, input logic n);
        return jk_op_t'({~q & n, q & ~n});
    endfunction

endpackage

// File: rtl/jk_mod_counter_cell.sv
// Single-bit behavioural JK register with synchronous active-high clear.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic cl,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (cl) begin
            q <= 1'b0;
        end else begin
            q <= jk_next(q, jk_op_t'({j, k}));
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from a bank of JK cells.
// Defining JK_COUNTER_EXCITE_OUT_EN exposes the J/K excitation vectors as jx/kx.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             en,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
`ifdef JK_COUNTER_EXCITE_OUT_EN
    output logic             wrap,
    output logic [WIDTH-1:0] jx,
    output logic [WIDTH-1:0] kx
`else
    output logic             wrap
`endif
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             wrap_nxt;

    // Target count; holding leaves nxt == q so the excitation is all zero.
    always_comb begin
        nxt      = q;
        wrap_nxt = 1'b0;
        if (ld) begin
            nxt = (din > MAX) ? MAX : din;
        end else if (en) begin
            if (q > MAX) begin
                nxt = '0;
            end else if (up) begin
                if (q == MAX) begin
                    nxt      = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = q + WIDTH'(1);
                end
            end else begin
                if (q == '0) begin
                    nxt      = MAX;
                    wrap_nxt = 1'b1;
                end else begin
                    nxt = q - WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (!cl) begin
            for (int i = 0; i < WIDTH; i++) begin
                {j[i], k[i]} = jk_excite(q[i], nxt[i]);
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .cl  (cl),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (cl) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end

    assign tc = en & (up ? (q == MAX) : (q == '0));

`ifdef JK_COUNTER_EXCITE_OUT_EN
    assign jx = j;
    assign kx = k;
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10) against an
// arithmetic reference model of the counting rules.
module tb_jk_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk = 1'b0;
    logic             cl  = 1'b1;
    logic             en  = 1'b0;
    logic             up  = 1'b1;
    logic             ld  = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
`ifdef JK_COUNTER_EXCITE_OUT_EN
    logic [WIDTH-1:0] jx;
    logic [WIDTH-1:0] kx;
`endif

    int checks = 0;
    int errors = 0;
    int m_q    = 0;
    int m_wrap = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk  (clk),
        .cl   (cl),
        .en   (en),
        .up   (up),
        .ld   (ld),
        .din  (din),
        .q    (q),
        .tc   (tc),
`ifdef JK_COUNTER_EXCITE_OUT_EN
        .wrap (wrap),
        .jx   (jx),
        .kx   (kx)
`else
        .wrap (wrap)
`endif
    );

    function automatic int exp_tc();
        if (!en) return 0;
        return up ? int'(m_q == MODULUS - 1) : int'(m_q == 0);
    endfunction

    task automatic set_in(input logic c, input logic l, input logic e,
                          input logic u, input logic [WIDTH-1:0] d);
        cl = c; ld = l; en = e; up = u; din = d;
        #1;
    endtask

    // One clock edge; the model applies the counting rules to the sampled inputs.
    task automatic tick();
        @(posedge clk);
        if (cl) begin
            m_q = 0; m_wrap = 0;
        end else if (ld) begin
            m_q = (int'(din) >= MODULUS) ? MODULUS - 1 : int'(din);
            m_wrap = 0;
        end else if (en) begin
            m_wrap = 0;
            if (m_q >= MODULUS) m_q = 0;
            else if (up) begin
                if (m_q == MODULUS - 1) begin m_q = 0; m_wrap = 1; end
                else m_q = m_q + 1;
            end else begin
                if (m_q == 0) begin m_q = MODULUS - 1; m_wrap = 1; end
                else m_q = m_q - 1;
            end
        end else begin
            m_wrap = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 1, 1, '0);
        tick();
        tick();
        checks++;
        if (q !== 4'd0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%0d wrap=%0b, required q=0 wrap=0", q, wrap);
        end
        set_in(0, 0, 1, 1, '0);
        tick();
        checks++;
        if (q !== 4'd1) begin
            errors++;
            $display("FAIL reset_release: q=%0d, required 1", q);
        end
    endtask

    task automatic test_up_wrap();
        set_in(1, 0, 0, 1, '0);
        tick();
        set_in(0, 0, 1, 1, '0);
        for (int i = 0; i < MODULUS + 2; i++) begin
            checks++;
            if (tc !== 1'(exp_tc())) begin
                errors++;
                $display("FAIL up_tc: q=%0d tc=%0b, required %0d", q, tc, exp_tc());
            end
            tick();
            checks++;
            if (q !== WIDTH'(m_q) || wrap !== 1'(m_wrap)) begin
                errors++;
                $display("FAIL up_step: q=%0d wrap=%0b, required q=%0d wrap=%0d",
                         q, wrap, m_q, m_wrap);
            end
        end
    endtask

    task automatic test_down_wrap();
        set_in(0, 1, 0, 0, 4'd0);
        tick();
        set_in(0, 0, 1, 0, '0);
        checks++;
        if (tc !== 1'b1) begin
            errors++;
            $display("FAIL down_tc: tc=%0b at q=%0d, required 1", tc, q);
        end
        tick();
        checks++;
        if (q !== 4'd9 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: q=%0d wrap=%0b, required q=9 wrap=1", q, wrap);
        end
        tick();
        checks++;
        if (q !== 4'd8 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_after: q=%0d wrap=%0b, required q=8 wrap=0", q, wrap);
        end
    endtask

    task automatic test_load_clamp();
        logic [WIDTH-1:0] exp_q [3] = '{4'd5, 4'd9, 4'd0};
        logic [WIDTH-1:0] dins  [3] = '{4'd5, 4'd13, 4'd7};
        logic             cls   [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            set_in(cls[i], 1, 1, 1, dins[i]);
            tick();
            checks++;
            if (q !== exp_q[i] || q !== WIDTH'(m_q) || wrap !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d: q=%0d wrap=%0b, required q=%0d wrap=0",
                         i, q, wrap, exp_q[i]);
            end
        end
    endtask

    task automatic test_hold_flip();
        logic dirs [3] = '{1'b1, 1'b0, 1'b1};
        logic [WIDTH-1:0] exp_q [3] = '{4'd5, 4'd4, 4'd5};
        set_in(0, 1, 0, 1, 4'd4);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, i[0], '0);
            checks++;
            if (tc !== 1'b0) begin
                errors++;
                $display("FAIL hold_tc: tc=%0b, required 0", tc);
            end
            tick();
            checks++;
            if (q !== 4'd4 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: q=%0d wrap=%0b, required q=4 wrap=0", i, q, wrap);
            end
        end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, dirs[i], '0);
            tick();
            checks++;
            if (q !== exp_q[i]) begin
                errors++;
                $display("FAIL flip_%0d: q=%0d, required %0d", i, q, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                   1'($urandom), 1'($urandom), 4'($urandom));
            checks++;
            if (tc !== 1'(exp_tc())) begin
                errors++;
                $display("FAIL rand_tc[%0d]: tc=%0b, required %0d", i, tc, exp_tc());
            end
            tick();
            checks++;
            if (q !== WIDTH'(m_q) || wrap !== 1'(m_wrap)) begin
                errors++;
                $display("FAIL rand_step[%0d]: q=%0d wrap=%0b, required q=%0d wrap=%0d",
                         i, q, wrap, m_q, m_wrap);
            end
        end
    endtask

`ifdef JK_COUNTER_EXCITE_OUT_EN
    task automatic test_excite();
        set_in(0, 1, 0, 1, 4'd5);
        tick();
        set_in(0, 0, 1, 1, '0);
        checks++;
        if (jx !== 4'b0010 || kx !== 4'b0001) begin
            errors++;
            $display("FAIL excite_count: jx=%b kx=%b, required jx=0010 kx=0001", jx, kx);
        end
        tick();
        checks++;
        if (q !== 4'd6) begin
            errors++;
            $display("FAIL excite_next: q=%0d, required 6", q);
        end
        set_in(0, 0, 0, 1, '0);
        checks++;
        if (jx !== 4'b0000 || kx !== 4'b0000) begin
            errors++;
            $display("FAIL excite_hold: jx=%b kx=%b, required 0000 0000", jx, kx);
        end
        set_in(1, 0, 1, 1, '0);
        checks++;
        if (jx !== 4'b0000 || kx !== 4'b0000) begin
            errors++;
            $display("FAIL excite_clear: jx=%b kx=%b, required 0000 0000", jx, kx);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_hold_flip();
`ifdef JK_COUNTER_EXCITE_OUT_EN
        test_excite();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
